// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_sync
// Purpose  : Oversampled SPI mode-0 slave clocked entirely by the system
//            clock. SCLK, SS and MOSI are resynchronised (2 flops + 1
//            history flop each). Words of M bits are received and a
//            parallel transmit word is shifted out on MISO. Several words
//            may be exchanged under a single SS assertion.
// Ports    : i_gclk      system clock (rising edge)
//            i_rst_n     asynchronous active-low reset
//            i_sclk      external serial clock (asynchronous)
//            i_ss        external slave select, active low (asynchronous)
//            i_mosi      external serial data in (asynchronous)
//            o_miso      serial data out
//            i_tx_data   word to transmit, loaded at frame start / word wrap
//            o_rx_data   last complete received word
//            o_rx_valid  one-cycle pulse when o_rx_data updates
//            o_rx_err    one-cycle pulse when a frame ends mid-word
//            o_busy      high while a frame is active
// Params   : M     word size in bits (2..32)
//            LEFT  1 = MSB first, 0 = LSB first
// Options  : SPI_SLAVE_SYNC_TRISTATE_EN - when defined, o_miso is driven only
//            while a frame is active and is high-impedance otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
  parameter int M    = 15,
  parameter bit LEFT = 1'b1
) (
  input  logic         i_gclk,
  input  logic         i_rst_n,
  input  logic         i_sclk,
  input  logic         i_ss,
  input  logic         i_mosi,
  output logic         o_miso,
  input  logic [M-1:0] i_tx_data,
  output logic [M-1:0] o_rx_data,
  output logic         o_rx_valid,
  output logic         o_rx_err,
  output logic         o_busy
);

  localparam int            CW     = $clog2(M + 1);
  localparam logic [CW-1:0] C_LAST = CW'(M - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // [0],[1] = synchroniser stages, [2] = history flop for edge detection
  logic [2:0]    r_sclk_pipe;
  logic [2:0]    r_ss_pipe;
  logic [2:0]    r_mosi_pipe;

  logic [CW-1:0] r_bit_cnt;
  logic [M-1:0]  r_rx_sh;
  logic [M-1:0]  r_tx_sh;
  logic [M-1:0]  w_rx_next;
  logic [M-1:0]  w_tx_shifted;
  logic          w_tx_bit;

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_start, w_stop, w_rise, w_fall;
  logic w_mosi;

  assign w_sclk_rise =  r_sclk_pipe[1] & ~r_sclk_pipe[2];
  assign w_sclk_fall = ~r_sclk_pipe[1] &  r_sclk_pipe[2];
  assign w_ss_rise   =  r_ss_pipe[1]   & ~r_ss_pipe[2];
  assign w_ss_fall   = ~r_ss_pipe[1]   &  r_ss_pipe[2];
  // MOSI taken from the history stage: it is the value seen at the same
  // instant SCLK was still low, i.e. just before the detected rising edge.
  assign w_mosi      = r_mosi_pipe[2];

  always_ff @(posedge i_gclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_pipe <= '0;
      r_ss_pipe   <= '0;
      r_mosi_pipe <= '0;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[1:0], i_sclk};
      r_ss_pipe   <= {r_ss_pipe[1:0],   i_ss};
      r_mosi_pipe <= {r_mosi_pipe[1:0], i_mosi};
    end
  end

  // State register
  always_ff @(posedge i_gclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle actions. SS rise wins over any SCLK edge seen
  // in the same cycle; SCLK edges in IDLE are ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_ACTIVE;
          w_start     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_stop      = 1'b1;
        end else begin
          w_rise = w_sclk_rise;
          w_fall = w_sclk_fall;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  generate
    if (LEFT) begin : g_msb_first
      assign w_rx_next    = {r_rx_sh[M-2:0], w_mosi};
      assign w_tx_shifted = {r_tx_sh[M-2:0], 1'b0};
      assign w_tx_bit     = r_tx_sh[M-1];
    end else begin : g_lsb_first
      assign w_rx_next    = {w_mosi, r_rx_sh[M-1:1]};
      assign w_tx_shifted = {1'b0, r_tx_sh[M-1:1]};
      assign w_tx_bit     = r_tx_sh[0];
    end
  endgenerate

  always_ff @(posedge i_gclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_rx_err   <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_rx_err   <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
        r_rx_sh   <= '0;
        r_tx_sh   <= i_tx_data;
      end
      // A nonzero count at frame end means a partial word: drop it.
      if (w_stop && (r_bit_cnt != '0)) begin
        o_rx_err <= 1'b1;
      end
      if (w_rise) begin
        r_rx_sh <= w_rx_next;
        if (r_bit_cnt == C_LAST) begin
          r_bit_cnt  <= '0;
          o_rx_data  <= w_rx_next;
          o_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
      // A zero count on a falling edge means a word just wrapped: reload.
      if (w_fall) begin
        if (r_bit_cnt == '0) begin
          r_tx_sh <= i_tx_data;
        end else begin
          r_tx_sh <= w_tx_shifted;
        end
      end
    end
  end

  assign o_busy = (r_state == S_ACTIVE);

`ifdef SPI_SLAVE_SYNC_TRISTATE_EN
  assign o_miso = o_busy ? w_tx_bit : 1'bz;
`else
  assign o_miso = o_busy & w_tx_bit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_sync
// Purpose  : Directed self-checking bench for spi_slave_sync. Two instances
//            (MSB-first and LSB-first) share the SPI pins; an SPI mode-0
//            master is modelled with tasks at 100 system clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync;

  localparam int M    = 15;
  localparam int HALF = 50;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk;
  logic         ss;
  logic         mosi;
  logic [M-1:0] tx_data;

  logic         miso_a, valid_a, err_a, busy_a;
  logic [M-1:0] rx_a;
  logic         miso_b, valid_b, err_b, busy_b;
  logic [M-1:0] rx_b;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt_a = 0, ecnt_a = 0, vcnt_b = 0, ecnt_b = 0;

  always #5 clk = ~clk;

  spi_slave_sync #(.M(M), .LEFT(1'b1)) dut (
    .i_gclk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso_a), .i_tx_data(tx_data), .o_rx_data(rx_a),
    .o_rx_valid(valid_a), .o_rx_err(err_a), .o_busy(busy_a)
  );

  spi_slave_sync #(.M(M), .LEFT(1'b0)) dut_l (
    .i_gclk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso_b), .i_tx_data(tx_data), .o_rx_data(rx_b),
    .o_rx_valid(valid_b), .o_rx_err(err_b), .o_busy(busy_b)
  );

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
    if (err_a   === 1'b1) ecnt_a <= ecnt_a + 1;
    if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
    if (err_b   === 1'b1) ecnt_b <= ecnt_b + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One word from the master; MISO of both instances captured at each rise.
  // next_tx is applied to tx_data between the last rise and the last fall.
  task automatic xfer(input logic [M-1:0] word, input bit lsb, input int nbits,
                      input logic [M-1:0] next_tx,
                      output logic [M-1:0] cap_a, output logic [M-1:0] cap_b);
    cap_a = '0;
    cap_b = '0;
    for (int k = 0; k < nbits; k++) begin
      int idx;
      idx  = lsb ? k : (M - 1 - k);
      mosi = word[idx];
      wait_cyc(HALF);
      cap_a[idx] = miso_a;
      cap_b[idx] = miso_b;
      sclk = 1'b1;
      if (k == M - 1) begin
        wait_cyc(20);
        tx_data = next_tx;
        wait_cyc(HALF - 20);
      end else begin
        wait_cyc(HALF);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic ss_low();
    ss = 1'b0;
    wait_cyc(10);
  endtask

  task automatic ss_high();
    wait_cyc(10);
    ss = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; tx_data = 15'h6B36;
    wait_cyc(3);
    n_cmp++;
    if ({busy_a, valid_a, err_a, miso_a, rx_a} !== {4'b0000, 15'h0000}) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b valid=%b err=%b miso=%b rx=%h, want all 0",
               busy_a, valid_a, err_a, miso_a, rx_a);
    end
    rst_n = 1'b1;
    wait_cyc(5);
    n_cmp++;
`ifdef SPI_SLAVE_SYNC_TRISTATE_EN
    if (miso_a !== 1'bz) begin
      n_bad++;
      $display("FAIL idle_miso: got %b want z", miso_a);
    end
`else
    if (miso_a !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_miso: got %b want 0", miso_a);
    end
`endif
  endtask

  task automatic test_idle_sclk();
    int v0;
    v0 = vcnt_a;
    for (int k = 0; k < M; k++) begin
      mosi = k[0];
      sclk = 1'b1; wait_cyc(8);
      sclk = 1'b0; wait_cyc(8);
    end
    wait_cyc(5);
    n_cmp++;
    if (vcnt_a !== v0 || busy_a !== 1'b0 || rx_a !== 15'h0000) begin
      n_bad++;
      $display("FAIL idle_sclk: got valids=%0d busy=%b rx=%h want %0d 0 0000",
               vcnt_a - v0, busy_a, rx_a, 0);
    end
  endtask

  task automatic test_basic();
    logic [M-1:0] ca, cb;
    int v0;
    v0 = vcnt_a;
    tx_data = 15'h6B36;
    ss = 1'b0;
    wait_cyc(2);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL busy_early: got %b want 0", busy_a);
    end
    wait_cyc(1);
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL busy_start: got %b want 1", busy_a);
    end
    wait_cyc(7);
    xfer(15'h2C36, 1'b0, M, 15'h6B36, ca, cb);
    wait_cyc(10);
    ss = 1'b1;
    wait_cyc(2);
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL busy_hold: got %b want 1", busy_a);
    end
    wait_cyc(1);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL busy_end: got %b want 0", busy_a);
    end
    wait_cyc(5);
    n_cmp++;
    if (rx_a !== 15'h2C36 || vcnt_a - v0 !== 1) begin
      n_bad++;
      $display("FAIL basic_rx: got rx=%h valids=%0d want 2c36 1", rx_a, vcnt_a - v0);
    end
    n_cmp++;
    if (ca !== 15'b110101100110110) begin
      n_bad++; $display("FAIL basic_miso: got %b want 110101100110110", ca);
    end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] ca1, cb1, ca2, cb2;
    int v0;
    v0 = vcnt_a;
    tx_data = 15'h6B36;
    ss_low();
    xfer(15'h2C36, 1'b0, M, 15'h0001, ca1, cb1);
    n_cmp++;
    if (rx_a !== 15'h2C36) begin
      n_bad++; $display("FAIL b2b_word1: got %h want 2c36", rx_a);
    end
    xfer(15'h7FFF, 1'b0, M, 15'h0001, ca2, cb2);
    ss_high();
    n_cmp++;
    if (rx_a !== 15'h7FFF || vcnt_a - v0 !== 2) begin
      n_bad++;
      $display("FAIL b2b_word2: got rx=%h valids=%0d want 7fff 2", rx_a, vcnt_a - v0);
    end
    n_cmp++;
    if (ca1 !== 15'h6B36 || ca2 !== 15'h0001) begin
      n_bad++;
      $display("FAIL b2b_miso: got %h %h want 6b36 0001", ca1, ca2);
    end
  endtask

  task automatic test_abort();
    logic [M-1:0] ca, cb;
    int v0, e0;
    v0 = vcnt_a; e0 = ecnt_a;
    ss_low();
    xfer(15'h1555, 1'b0, 7, tx_data, ca, cb);
    ss_high();
    n_cmp++;
    if (ecnt_a - e0 !== 1 || vcnt_a !== v0 || rx_a !== 15'h7FFF) begin
      n_bad++;
      $display("FAIL abort: got errs=%0d valids=%0d rx=%h want 1 0 7fff",
               ecnt_a - e0, vcnt_a - v0, rx_a);
    end
    ss_low();
    xfer(15'h5A5A, 1'b0, M, tx_data, ca, cb);
    ss_high();
    n_cmp++;
    if (rx_a !== 15'h5A5A || vcnt_a - v0 !== 1 || ecnt_a - e0 !== 1) begin
      n_bad++;
      $display("FAIL after_abort: got rx=%h valids=%0d errs=%0d want 5a5a 1 1",
               rx_a, vcnt_a - v0, ecnt_a - e0);
    end
  endtask

  task automatic test_lsb_first();
    logic [M-1:0] ca, cb;
    tx_data = 15'h0001;
    ss_low();
    xfer(15'h2C36, 1'b1, M, 15'h0001, ca, cb);
    ss_high();
    n_cmp++;
    if (rx_b !== 15'h2C36) begin
      n_bad++; $display("FAIL lsb_rx: got %h want 2c36", rx_b);
    end
    n_cmp++;
    if (cb[0] !== 1'b1 || cb !== 15'h0001) begin
      n_bad++; $display("FAIL lsb_miso: got %h want 0001", cb);
    end
  endtask

  task automatic test_reset_midframe();
    logic [M-1:0] ca, cb;
    int v0, e0;
    tx_data = 15'h6B36;
    ss_low();
    xfer(15'h2C36, 1'b0, 8, tx_data, ca, cb);
    wait_cyc(5);
    v0 = vcnt_a; e0 = ecnt_a;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy_a, valid_a, err_a, miso_a, rx_a} !== {4'b0000, 15'h0000}) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%b valid=%b err=%b miso=%b rx=%h want all 0",
               busy_a, valid_a, err_a, miso_a, rx_a);
    end
    wait_cyc(2);
    rst_n = 1'b1;
    ss_high();
    wait_cyc(10);
    n_cmp++;
    if (vcnt_a !== v0 || ecnt_a !== e0) begin
      n_bad++;
      $display("FAIL reset_pulses: got valids=%0d errs=%0d want 0 0",
               vcnt_a - v0, ecnt_a - e0);
    end
    ss_low();
    xfer(15'h1234, 1'b0, M, tx_data, ca, cb);
    ss_high();
    n_cmp++;
    if (rx_a !== 15'h1234 || vcnt_a - v0 !== 1) begin
      n_bad++;
      $display("FAIL post_reset_rx: got rx=%h valids=%0d want 1234 1", rx_a, vcnt_a - v0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_sclk();
    test_basic();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
